// File: rtl/zap_mode16_halfword_aligner_pkg.sv
// Shared constants and types for the 16-bit halfword aligner.
// The state constants are plain localparams so older code can keep using them.
package zap_mode16_halfword_aligner_pkg;

    localparam logic [0:0] ALIGN_IDLE = 1'b0;
    localparam logic [0:0] ALIGN_HOLD = 1'b1;

    // Predictor state for a buffered upper halfword: weakly not taken.
    localparam logic [1:0] WEAK_NT = 2'b01;

    typedef struct packed {
        logic [15:0] hw;
        logic [31:0] pc;
        logic [31:0] pc8;
    } hw_buf_t;

endpackage

// File: rtl/zap_mode16_halfword_aligner.sv
// Splits 32-bit fetch words into 16-bit instructions in compressed mode and
// passes whole words through otherwise; one registered instruction per cycle.
module zap_mode16_halfword_aligner
    import zap_mode16_halfword_aligner_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_stall,
    input  logic        i_cpsr_ff_t,
    input  logic [31:0] i_instruction,
    input  logic        i_instruction_valid,
    input  logic [31:0] i_pc_ff,
    input  logic [31:0] i_pc_plus_8_ff,
    input  logic [1:0]  i_taken,
    input  logic [32:0] i_pred,
    input  logic        i_iabort,
    input  logic        i_irq,
    input  logic        i_fiq,
    output logic        o_stall_fetch,
    output logic [31:0] o_instruction,
    output logic        o_instruction_valid,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_taken_ff,
    output logic [32:0] o_pred,
    output logic        o_iabort,
    output logic        o_irq,
    output logic        o_fiq,
    output logic [0:0]  o_align_state
);

    // Handshake: an input word is accepted on a clock edge where i_instruction_valid
    // is high, the state is IDLE and neither i_clear nor i_stall is asserted; fetch
    // must hold its word while o_stall_fetch is high.

    logic [0:0] state;
    hw_buf_t    hbuf;

    assign o_stall_fetch = (state == ALIGN_HOLD);
    assign o_align_state = state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state               <= ALIGN_IDLE;
            hbuf                <= '0;
            o_instruction       <= '0;
            o_instruction_valid <= 1'b0;
            o_pc_ff             <= '0;
            o_pc_plus_8_ff      <= '0;
            o_taken_ff          <= '0;
            o_pred              <= '0;
            o_iabort            <= 1'b0;
            o_irq               <= 1'b0;
            o_fiq               <= 1'b0;
        end else if (i_clear) begin
            state               <= ALIGN_IDLE;
            o_instruction_valid <= 1'b0;
            o_iabort            <= 1'b0;
            o_irq               <= 1'b0;
            o_fiq               <= 1'b0;
        end else if (!i_stall) begin
            if (state == ALIGN_HOLD) begin
                // Fetch is holding the next word, so the input qualifier is ignored here.
                state               <= ALIGN_IDLE;
                o_instruction       <= {16'd0, hbuf.hw};
                o_instruction_valid <= 1'b1;
                o_pc_ff             <= hbuf.pc;
                o_pc_plus_8_ff      <= hbuf.pc8;
                o_taken_ff          <= WEAK_NT;
                o_pred              <= '0;
                o_iabort            <= 1'b0;
                o_irq               <= i_irq;
                o_fiq               <= i_fiq;
            end else if (!i_instruction_valid) begin
                o_instruction_valid <= 1'b0;
                o_iabort            <= 1'b0;
                o_irq               <= 1'b0;
                o_fiq               <= 1'b0;
            end else begin
                o_instruction_valid <= 1'b1;
                o_pc_ff             <= i_pc_ff;
                o_pc_plus_8_ff      <= i_pc_plus_8_ff;
                o_taken_ff          <= i_taken;
                o_pred              <= i_pred;
                o_iabort            <= i_iabort;
                o_irq               <= i_irq;
                o_fiq               <= i_fiq;
                if (!i_cpsr_ff_t) begin
                    o_instruction <= i_instruction;
                end else if (i_pc_ff[1]) begin
                    o_instruction <= {16'd0, i_instruction[31:16]};
                end else begin
                    o_instruction <= {16'd0, i_instruction[15:0]};
                    // An abort or a taken prediction on the lower half makes the upper half dead.
                    if (!i_iabort && !i_taken[1]) begin
                        hbuf.hw  <= i_instruction[31:16];
                        hbuf.pc  <= i_pc_ff + 32'd2;
                        hbuf.pc8 <= i_pc_plus_8_ff + 32'd2;
                        state    <= ALIGN_HOLD;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_zap_mode16_halfword_aligner.sv
// Bench for the halfword aligner: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_zap_mode16_halfword_aligner;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        stall;
    logic        t;
    logic [31:0] word;
    logic        word_valid;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [1:0]  taken;
    logic [32:0] pred;
    logic        iabort;
    logic        irq;
    logic        fiq;
    logic        stall_fetch;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] o_pc;
    logic [31:0] o_pc8;
    logic [1:0]  o_taken;
    logic [32:0] o_pred;
    logic        o_iabort;
    logic        o_irq;
    logic        o_fiq;
    logic [0:0]  align_state;

    int n_tests;
    int n_fail;

    zap_mode16_halfword_aligner dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_clear             (clear),
        .i_stall             (stall),
        .i_cpsr_ff_t         (t),
        .i_instruction       (word),
        .i_instruction_valid (word_valid),
        .i_pc_ff             (pc),
        .i_pc_plus_8_ff      (pc8),
        .i_taken             (taken),
        .i_pred              (pred),
        .i_iabort            (iabort),
        .i_irq               (irq),
        .i_fiq               (fiq),
        .o_stall_fetch       (stall_fetch),
        .o_instruction       (instr),
        .o_instruction_valid (instr_valid),
        .o_pc_ff             (o_pc),
        .o_pc_plus_8_ff      (o_pc8),
        .o_taken_ff          (o_taken),
        .o_pred              (o_pred),
        .o_iabort            (o_iabort),
        .o_irq               (o_irq),
        .o_fiq               (o_fiq),
        .o_align_state       (align_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        reset = 1'b0; clear = 1'b0; stall = 1'b0; t = 1'b0;
        word = '0; word_valid = 1'b0; pc = '0; pc8 = '0; taken = '0;
        pred = '0; iabort = 1'b0; irq = 1'b0; fiq = 1'b0;
    endtask

    task automatic drive_word(input logic tm, input logic [31:0] w, input logic [31:0] a,
                              input logic [1:0] tk, input logic ab);
        t = tm; word = w; word_valid = 1'b1; pc = a; pc8 = a + 32'd8; taken = tk; iabort = ab;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: halfwords still owed to the decoder, packed {hw, pc, pc8}
    logic [79:0] exp_q[$];
    logic        m_valid, m_iabort, m_irq, m_fiq, m_known;
    logic [31:0] m_instr, m_pc, m_pc8;
    logic [1:0]  m_taken;
    logic [32:0] m_pred;

    task automatic model_reset();
        exp_q.delete();
        m_valid = 0; m_iabort = 0; m_irq = 0; m_fiq = 0; m_known = 1;
        m_instr = '0; m_pc = '0; m_pc8 = '0; m_taken = '0; m_pred = '0;
    endtask

    task automatic model_step();
        logic [79:0] e;
        if (clear) begin
            exp_q.delete();
            m_valid = 0; m_iabort = 0; m_irq = 0; m_fiq = 0; m_known = 0;
        end else if (stall) begin
            // everything frozen
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m_instr = {16'd0, e[79:64]}; m_pc = e[63:32]; m_pc8 = e[31:0];
            m_taken = 2'b01; m_pred = '0; m_iabort = 0; m_irq = irq; m_fiq = fiq;
            m_valid = 1; m_known = 1;
        end else if (!word_valid) begin
            m_valid = 0; m_iabort = 0; m_irq = 0; m_fiq = 0;
        end else begin
            m_valid = 1; m_known = 1; m_pc = pc; m_pc8 = pc8; m_taken = taken;
            m_pred = pred; m_iabort = iabort; m_irq = irq; m_fiq = fiq;
            if (!t) m_instr = word;
            else if (pc[1]) m_instr = {16'd0, word[31:16]};
            else begin
                m_instr = {16'd0, word[15:0]};
                if (!iabort && !taken[1]) exp_q.push_back({word[31:16], pc + 32'd2, pc8 + 32'd2});
            end
        end
    endtask

    task automatic model_check();
        check("rnd_valid", instr_valid, m_valid);
        check("rnd_iabort", o_iabort, m_iabort);
        check("rnd_irq", o_irq, m_irq);
        check("rnd_fiq", o_fiq, m_fiq);
        check("rnd_stall_fetch", stall_fetch, exp_q.size() != 0);
        if (m_valid) begin
            check("rnd_instr", instr, m_instr);
            check("rnd_pc", o_pc, m_pc);
            check("rnd_pc8", o_pc8, m_pc8);
            check("rnd_taken", o_taken, m_taken);
            check("rnd_pred", o_pred, m_pred);
        end else if (m_known) begin
            check("rnd_instr_hold", instr, m_instr);
        end
    endtask

    typedef struct {
        logic        t;
        logic        vld;
        logic [31:0] word;
        logic [31:0] pc;
        logic [1:0]  taken;
        logic        abort;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc8;
        logic [1:0]  e_taken;
        logic        e_abort;
        logic        e_stall;
    } vec_t;

    vec_t vecs[10];

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{1'b0, 1'b1, 32'hE3A00001, 32'h100, 2'b00, 1'b0, 1'b1, 32'hE3A00001, 32'h100, 32'h108, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hE3A00002, 32'h104, 2'b00, 1'b0, 1'b1, 32'hE3A00002, 32'h104, 32'h10C, 2'b00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h22012001, 32'h200, 2'b00, 1'b0, 1'b1, 32'h00002001, 32'h200, 32'h208, 2'b00, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h204, 2'b00, 1'b0, 1'b1, 32'h00002201, 32'h202, 32'h20A, 2'b01, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h11115555, 32'h206, 2'b00, 1'b0, 1'b1, 32'h00001111, 32'h206, 32'h20E, 2'b00, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h99999999, 32'h208, 2'b00, 1'b0, 1'b0, 32'h00001111, 32'h0,   32'h0,   2'b00, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h33334444, 32'h300, 2'b10, 1'b0, 1'b1, 32'h00004444, 32'h300, 32'h308, 2'b10, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h55556666, 32'h304, 2'b00, 1'b1, 1'b1, 32'h00006666, 32'h304, 32'h30C, 2'b00, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h77778888, 32'h308, 2'b00, 1'b0, 1'b0, 32'h00006666, 32'h0,   32'h0,   2'b00, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 32'h12345678, 32'h400, 2'b11, 1'b1, 1'b1, 32'h12345678, 32'h400, 32'h408, 2'b11, 1'b1, 1'b0};

        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        check("reset_valid", instr_valid, 1'b0);
        check("reset_instr", instr, 32'h0);
        check("reset_pc", o_pc, 32'h0);
        check("reset_pred", o_pred, 33'h0);
        check("reset_stall_fetch", stall_fetch, 1'b0);
        check("reset_status", {o_iabort, o_irq, o_fiq, o_taken}, 5'b0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            drive_word(vecs[i].t, vecs[i].word, vecs[i].pc, vecs[i].taken, vecs[i].abort);
            word_valid = vecs[i].vld;
            tick();
            check($sformatf("vec%0d_valid", i), instr_valid, vecs[i].e_vld);
            check($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
            check($sformatf("vec%0d_iabort", i), o_iabort, vecs[i].e_abort);
            check($sformatf("vec%0d_stall_fetch", i), stall_fetch, vecs[i].e_stall);
            if (vecs[i].e_vld) begin
                check($sformatf("vec%0d_pc", i), o_pc, vecs[i].e_pc);
                check($sformatf("vec%0d_pc8", i), o_pc8, vecs[i].e_pc8);
                check($sformatf("vec%0d_taken", i), o_taken, vecs[i].e_taken);
            end
        end

        // Stall while holding a buffered halfword
        drive_idle();
        drive_word(1'b1, 32'hAAAA5555, 32'h500, 2'b00, 1'b0);
        tick();
        check("hold_enter_stall", stall_fetch, 1'b1);
        check("hold_enter_instr", instr, 32'h00005555);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_frz%0d_stall", i), stall_fetch, 1'b1);
            check($sformatf("hold_frz%0d_instr", i), instr, 32'h00005555);
            check($sformatf("hold_frz%0d_pc", i), o_pc, 32'h500);
            check($sformatf("hold_frz%0d_valid", i), instr_valid, 1'b1);
        end
        stall = 1'b0;
        tick();
        check("hold_rel_instr", instr, 32'h0000AAAA);
        check("hold_rel_pc", o_pc, 32'h502);
        check("hold_rel_pc8", o_pc8, 32'h50A);
        check("hold_rel_stall", stall_fetch, 1'b0);
        word_valid = 1'b0;
        tick();
        check("hold_nodup_valid", instr_valid, 1'b0);

        // Clear together with stall drops the buffered halfword
        drive_word(1'b1, 32'hBBBB7777, 32'h600, 2'b00, 1'b0);
        tick();
        check("clr_enter_stall", stall_fetch, 1'b1);
        word_valid = 1'b0; clear = 1'b1; stall = 1'b1;
        tick();
        check("clr_valid", instr_valid, 1'b0);
        check("clr_stall", stall_fetch, 1'b0);
        clear = 1'b0; stall = 1'b0;
        tick();
        check("clr_after_valid", instr_valid, 1'b0);

        // Reset mid-HOLD behaves the same, next accept starts clean
        drive_word(1'b1, 32'hCCCC8888, 32'h700, 2'b00, 1'b0);
        tick();
        check("rst_enter_stall", stall_fetch, 1'b1);
        word_valid = 1'b0; reset = 1'b1;
        tick();
        check("rst_valid", instr_valid, 1'b0);
        check("rst_stall", stall_fetch, 1'b0);
        reset = 1'b0;
        tick();
        check("rst_after_valid", instr_valid, 1'b0);
        drive_word(1'b1, 32'hDDDD9999, 32'h704, 2'b00, 1'b0);
        tick();
        check("rst_new_instr", instr, 32'h00009999);
        check("rst_new_pc", o_pc, 32'h704);
        check("rst_new_stall", stall_fetch, 1'b1);

        // Randomized run against the reference model
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            clear      = ($urandom_range(0, 15) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            word_valid = ($urandom_range(0, 3) != 0);
            t          = $urandom_range(0, 1);
            pc         = ($urandom() & 32'hFFFF_FFFC) | {30'd0, 1'($urandom_range(0, 1)), 1'b0};
            pc8        = pc + 32'd8;
            word       = $urandom();
            taken      = 2'($urandom_range(0, 3));
            pred       = {1'($urandom_range(0, 1)), 32'($urandom())};
            iabort     = ($urandom_range(0, 7) == 0);
            irq        = $urandom_range(0, 1);
            fiq        = $urandom_range(0, 1);
            model_step();
            tick();
            model_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
